// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing from a DivClk-derived pixel strobe (Clk domain); `define VGA_SYNC_FRAME_TICK_EN adds frame_tick
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       DivClk,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);
  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic       r_div_q;
  logic       r_started;
  logic       w_h_end;
  logic       w_v_end;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  assign w_h_end = pixel_x == H_LAST;
  assign w_v_end = pixel_y == V_LAST;
  assign w_h_nxt = p_tick ? (w_h_end ? 10'd0 : pixel_x + 10'd1) : pixel_x;
  assign w_v_nxt = (p_tick && w_h_end) ? (w_v_end ? 10'd0 : pixel_y + 10'd1) : pixel_y;
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_div_q   <= 1'b0;
      p_tick    <= 1'b0;
      r_started <= 1'b0;
      pixel_x   <= 10'd0;
      pixel_y   <= 10'd0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_on  <= 1'b0;
    end else begin
      r_div_q   <= DivClk;
      p_tick    <= DivClk & ~r_div_q;
      r_started <= r_started | p_tick;
      pixel_x   <= w_h_nxt;
      pixel_y   <= w_v_nxt;
      hsync     <= !(w_h_nxt >= HS_LO && w_h_nxt <= HS_HI);
      vsync     <= !(w_v_nxt >= VS_LO && w_v_nxt <= VS_HI);
      video_on  <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS) && (r_started || p_tick);
    end
  end
`ifdef VGA_SYNC_FRAME_TICK_EN
  always_ff @(posedge Clk)
    frame_tick <= reset ? 1'b0 : p_tick && w_h_end && w_v_end;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen at full 640x480 timing and on a scaled 24x15 instance
module tb_vga_sync_gen;
  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic DivClk = 1'b0;
  logic pt_f, hs_f, vs_f, vo_f, ft_f;
  logic pt_s, hs_s, vs_s, vo_s, ft_s;
  logic [9:0] px_f, py_f, px_s, py_s;
  int errs = 0;
  int checks = 0;
  int fh, fv, sh, sv;
  logic st, s_wrap;
  always #5 Clk = ~Clk;
  vga_sync_gen u_full (
    .Clk(Clk), .reset(reset), .DivClk(DivClk), .p_tick(pt_f), .hsync(hs_f), .vsync(vs_f),
    .video_on(vo_f), .pixel_x(px_f), .pixel_y(py_f)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft_f)
`endif
  );
  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .Clk(Clk), .reset(reset), .DivClk(DivClk), .p_tick(pt_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(vo_s), .pixel_x(px_s), .pixel_y(py_s)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft_s)
`endif
  );
`ifndef VGA_SYNC_FRAME_TICK_EN
  assign ft_f = 1'b0;
  assign ft_s = 1'b0;
`endif
  function automatic logic [22:0] exp_f(int h, int v, logic s);
    return {!(h >= 656 && h <= 751), !(v == 490 || v == 491), s && h < 640 && v < 480, 10'(h), 10'(v)};
  endfunction
  function automatic logic [22:0] exp_s(int h, int v, logic s);
    return {!(h >= 18 && h <= 20), !(v == 10 || v == 11), s && h < 16 && v < 8, 10'(h), 10'(v)};
  endfunction
  task automatic advance();
    s_wrap = sh == 23 && sv == 14;
    if (fh == 799) begin fh = 0; fv = (fv == 524) ? 0 : fv + 1; end else fh++;
    if (sh == 23) begin sh = 0; sv = (sv == 14) ? 0 : sv + 1; end else sh++;
    st = 1'b1;
  endtask
  task automatic strobe();
    DivClk = 1'b1;
    @(posedge Clk); #1;
    DivClk = 1'b0;
    @(posedge Clk); #1;
    advance();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DivClk = i[1];
      @(posedge Clk); #1;
      checks += 2;
      if ({pt_f, hs_f, vs_f, vo_f, px_f, py_f} !== {4'b0110, 20'd0}) begin
        errs++; $display("FAIL reset_full cyc=%0d got %h exp %h", i, {pt_f, hs_f, vs_f, vo_f, px_f, py_f}, {4'b0110, 20'd0});
      end
      if ({pt_s, hs_s, vs_s, vo_s, px_s, py_s} !== {4'b0110, 20'd0}) begin
        errs++; $display("FAIL reset_small cyc=%0d got %h exp %h", i, {pt_s, hs_s, vs_s, vo_s, px_s, py_s}, {4'b0110, 20'd0});
      end
    end
    DivClk = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b0;
    @(posedge Clk); #1;
    fh = 0; fv = 0; sh = 0; sv = 0; st = 1'b0;
    checks++;
    if ({pt_f, hs_f, vs_f, vo_f, px_f, py_f} !== {4'b0110, 20'd0}) begin
      errs++; $display("FAIL release_idle got %h exp %h", {pt_f, hs_f, vs_f, vo_f, px_f, py_f}, {4'b0110, 20'd0});
    end
  endtask
  task automatic test_line();
    int hs_low, vid, first, last;
    hs_low = 0; vid = 0; first = -1; last = -1;
    repeat (800) begin
      strobe();
      checks += 2;
      if ({hs_f, vs_f, vo_f, px_f, py_f} !== exp_f(fh, fv, st)) begin
        errs++; $display("FAIL line_full at %0d,%0d got %h exp %h", fh, fv, {hs_f, vs_f, vo_f, px_f, py_f}, exp_f(fh, fv, st));
      end
      if ({hs_s, vs_s, vo_s, px_s, py_s} !== exp_s(sh, sv, st)) begin
        errs++; $display("FAIL line_small at %0d,%0d got %h exp %h", sh, sv, {hs_s, vs_s, vo_s, px_s, py_s}, exp_s(sh, sv, st));
      end
      if (!hs_f) begin hs_low++; if (first < 0) first = int'(px_f); last = int'(px_f); end
      if (vo_f && py_f == 10'd0) vid++;
    end
    checks += 5;
    if ({px_f, py_f} !== {10'd0, 10'd1}) begin errs++; $display("FAIL line_end_pos got %0d,%0d exp 0,1", px_f, py_f); end
    if (hs_low != 96) begin errs++; $display("FAIL hsync_width got %0d exp 96", hs_low); end
    if (first != 656) begin errs++; $display("FAIL hsync_first got %0d exp 656", first); end
    if (last != 751) begin errs++; $display("FAIL hsync_last got %0d exp 751", last); end
    if (vid != 639) begin errs++; $display("FAIL video_row0 got %0d exp 639", vid); end
  endtask
  task automatic test_frame();
    int vs_low, vid, vid_bad, pulses, idx0, idx1;
    logic seen_last, seen_wrap;
    vs_low = 0; vid = 0; vid_bad = 0; pulses = 0; idx0 = -1; idx1 = -1; seen_last = 1'b0; seen_wrap = 1'b0;
    for (int i = 0; i < 720; i++) begin
      strobe();
      checks++;
      if ({hs_s, vs_s, vo_s, px_s, py_s} !== exp_s(sh, sv, st)) begin
        errs++; $display("FAIL frame_small at %0d,%0d got %h exp %h", sh, sv, {hs_s, vs_s, vo_s, px_s, py_s}, exp_s(sh, sv, st));
      end
      if (!vs_s) vs_low++;
      if (vo_s) vid++;
      if (vo_s && sv >= 8) vid_bad++;
      if (sh == 23 && sv == 14) seen_last = 1'b1;
      if (s_wrap && seen_last && sh == 0 && sv == 0) seen_wrap = 1'b1;
`ifdef VGA_SYNC_FRAME_TICK_EN
      checks += 2;
      if (ft_s !== s_wrap) begin errs++; $display("FAIL frame_tick_small i=%0d got %b exp %b", i, ft_s, s_wrap); end
      if (ft_f !== 1'b0) begin errs++; $display("FAIL frame_tick_full i=%0d got %b exp 0", i, ft_f); end
      if (ft_s === 1'b1) begin
        pulses++;
        if (idx0 < 0) idx0 = i; else idx1 = i;
        @(posedge Clk); #1;
        checks++;
        if (ft_s !== 1'b0) begin errs++; $display("FAIL frame_tick_width i=%0d got %b exp 0", i, ft_s); end
      end
`endif
    end
    checks += 5;
    if (vs_low != 96) begin errs++; $display("FAIL vsync_width got %0d exp 96", vs_low); end
    if (vid != 256) begin errs++; $display("FAIL video_frame got %0d exp 256", vid); end
    if (vid_bad != 0) begin errs++; $display("FAIL video_blank_rows got %0d exp 0", vid_bad); end
    if (!seen_last) begin errs++; $display("FAIL frame_last got %b exp 1", seen_last); end
    if (!seen_wrap) begin errs++; $display("FAIL frame_wrap got %b exp 1", seen_wrap); end
`ifdef VGA_SYNC_FRAME_TICK_EN
    checks += 2;
    if (pulses != 2) begin errs++; $display("FAIL frame_tick_count got %0d exp 2", pulses); end
    if (idx1 - idx0 != 360) begin errs++; $display("FAIL frame_tick_spacing got %0d exp 360", idx1 - idx0); end
`endif
  endtask
  task automatic test_static();
    DivClk = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge Clk); #1;
      checks += 2;
      if ({pt_f, pt_s} !== 2'b00) begin errs++; $display("FAIL static_ptick cyc=%0d got %b exp 00", i, {pt_f, pt_s}); end
      if ({hs_f, vs_f, vo_f, px_f, py_f} !== exp_f(fh, fv, st)) begin
        errs++; $display("FAIL static_hold cyc=%0d got %h exp %h", i, {hs_f, vs_f, vo_f, px_f, py_f}, exp_f(fh, fv, st));
      end
    end
  endtask
  task automatic test_back_to_back();
    DivClk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      if (k == 1) advance();
      checks += 2;
      if (pt_f !== (k == 0)) begin errs++; $display("FAIL long_high_ptick k=%0d got %b exp %b", k, pt_f, k == 0); end
      if ({hs_f, vs_f, vo_f, px_f, py_f} !== exp_f(fh, fv, st)) begin
        errs++; $display("FAIL long_high_pos k=%0d got %h exp %h", k, {hs_f, vs_f, vo_f, px_f, py_f}, exp_f(fh, fv, st));
      end
    end
    DivClk = 1'b0;
    @(posedge Clk); #1;
    repeat (4) begin
      DivClk = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (pt_f !== 1'b1) begin errs++; $display("FAIL b2b_ptick_hi got %b exp 1", pt_f); end
      DivClk = 1'b0;
      @(posedge Clk); #1;
      advance();
      checks += 2;
      if (pt_f !== 1'b0) begin errs++; $display("FAIL b2b_ptick_lo got %b exp 0", pt_f); end
      if ({hs_f, vs_f, vo_f, px_f, py_f} !== exp_f(fh, fv, st)) begin
        errs++; $display("FAIL b2b_pos got %h exp %h", {hs_f, vs_f, vo_f, px_f, py_f}, exp_f(fh, fv, st));
      end
    end
  endtask
  task automatic test_reset_mid();
    while (fh != 700) strobe();
    checks++;
    if (hs_f !== 1'b0) begin errs++; $display("FAIL mid_hsync_pre got %b exp 0", hs_f); end
    DivClk = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (pt_f !== 1'b1) begin errs++; $display("FAIL mid_ptick got %b exp 1", pt_f); end
    reset = 1'b1;
    DivClk = 1'b0;
    @(posedge Clk); #1;
    checks += 3;
    if ({pt_f, hs_f, vs_f, vo_f, px_f, py_f} !== {4'b0110, 20'd0}) begin
      errs++; $display("FAIL mid_reset_full got %h exp %h", {pt_f, hs_f, vs_f, vo_f, px_f, py_f}, {4'b0110, 20'd0});
    end
    if ({pt_s, hs_s, vs_s, vo_s, px_s, py_s} !== {4'b0110, 20'd0}) begin
      errs++; $display("FAIL mid_reset_small got %h exp %h", {pt_s, hs_s, vs_s, vo_s, px_s, py_s}, {4'b0110, 20'd0});
    end
    if ({ft_f, ft_s} !== 2'b00) begin errs++; $display("FAIL mid_reset_ftick got %b exp 00", {ft_f, ft_s}); end
    reset = 1'b0;
    fh = 0; fv = 0; sh = 0; sv = 0; st = 1'b0;
    repeat (3) begin
      strobe();
      checks += 2;
      if ({hs_f, vs_f, vo_f, px_f, py_f} !== exp_f(fh, fv, st)) begin
        errs++; $display("FAIL mid_resume_full got %h exp %h", {hs_f, vs_f, vo_f, px_f, py_f}, exp_f(fh, fv, st));
      end
      if ({hs_s, vs_s, vo_s, px_s, py_s} !== exp_s(sh, sv, st)) begin
        errs++; $display("FAIL mid_resume_small got %h exp %h", {hs_s, vs_s, vo_s, px_s, py_s}, exp_s(sh, sv, st));
      end
    end
    checks++;
    if ({px_f, py_f} !== {10'd3, 10'd0}) begin errs++; $display("FAIL mid_resume_pos got %0d,%0d exp 3,0", px_f, py_f); end
  endtask
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_static();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
